// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Triggered capture sequencer for an ADC sample stream. A start command
// arms a capture: a pre-trigger window is filled in a circular sample RAM,
// then the block waits for a level crossing (or a forced trigger), writes
// a post-trigger window and parks in DONE until the readout acknowledges.
// Only the write port of an external single-port RAM is driven here.
//
// Ports:
//   ad_clk      ADC sample clock, the only clock
//   rst_n       synchronous reset, active low
//   ad_data     raw ADC sample, valid every cycle
//   start       one-cycle capture request (honoured in IDLE only)
//   abort       one-cycle cancel, wins over everything else
//   ack         readout consumed the buffer, DONE -> IDLE
//   force_trig  immediate trigger while armed
//   trig_level  unsigned trigger threshold, used live
//   trig_slope  0 = rising, 1 = falling, used live
//   pre_len     pre-trigger sample count, latched at start
//   post_len    post-trigger sample count incl. trigger sample, latched at start
//   wr_en/wr_addr/wr_data  registered RAM write port
//   busy/armed/done        state decode
//   trig_addr   RAM address of the trigger sample
//   start_addr  RAM address of the oldest captured sample
//   forced      last trigger came from force_trig
module adc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W:0]   post_len,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              armed,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              forced
);

  localparam logic [ADDR_W:0]   DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] smp_q, prev_q;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_len_q, pre_len_d;
  logic [ADDR_W:0]   post_eff_q, post_eff_d;
  logic              armed_seen_q, armed_seen_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              forced_q, forced_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q;

  logic [ADDR_W:0]   room;
  logic [ADDR_W:0]   post_eff_in;
  logic              level_hit;
  logic              fire;
  logic              pre_last;
  logic              post_last;
  logic              writing;

  // The post window is clipped so pre + post never exceeds the RAM, and
  // it is never shorter than the trigger sample itself.
  always_comb begin
    room        = DEPTH_V - {1'b0, pre_len};
    post_eff_in = (post_len < room) ? post_len : room;
    if (post_eff_in == '0) begin
      post_eff_in = CNT_ONE;
    end
  end

  // Trigger qualification. The level test looks at the sample being
  // written this cycle and the one before it; it is only trusted once
  // ARMED has written at least one sample so prev is part of the capture.
  always_comb begin
    if (trig_slope) begin
      level_hit = (prev_q > trig_level) && (smp_q <= trig_level);
    end else begin
      level_hit = (prev_q < trig_level) && (smp_q >= trig_level);
    end
    fire      = (state_q == S_ARMED) && !abort &&
                (force_trig || (armed_seen_q && level_hit));
    pre_last  = (cnt_q == ({1'b0, pre_len_q} - CNT_ONE));
    post_last = (cnt_q == (post_eff_q - CNT_ONE));
    writing   = !abort &&
                ((state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST));
  end

  // State register.
  always_ff @(posedge ad_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (pre_len != '0) ? S_PRE : S_ARMED;
        S_PRE:   if (pre_last) state_d = S_ARMED;
        S_ARMED: if (fire) state_d = (post_eff_q == CNT_ONE) ? S_DONE : S_POST;
        S_POST:  if (post_last) state_d = S_DONE;
        S_DONE:  if (ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: window parameters are latched at start, every
  // writing state stores smp at wptr, and a trigger records where the
  // window lives in the circular buffer. cnt restarts at 1 on the trigger
  // because the trigger sample is the first post-window write.
  always_comb begin
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    pre_len_d    = pre_len_q;
    post_eff_d   = post_eff_q;
    armed_seen_d = armed_seen_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    forced_d     = forced_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    if (!abort && (state_q == S_IDLE) && start) begin
      pre_len_d    = pre_len;
      post_eff_d   = post_eff_in;
      wptr_d       = '0;
      cnt_d        = '0;
      armed_seen_d = 1'b0;
    end
    if (writing) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wptr_q;
      wptr_d    = wptr_q + ADDR_ONE;
      cnt_d     = cnt_q + CNT_ONE;
    end
    if (writing && (state_q == S_ARMED)) begin
      armed_seen_d = 1'b1;
    end
    if (fire) begin
      trig_addr_d  = wptr_q;
      start_addr_d = wptr_q - pre_len_q;
      forced_d     = force_trig;
      cnt_d        = CNT_ONE;
    end
  end

  // Datapath registers and the two-stage sample pipeline feeding wr_data.
  always_ff @(posedge ad_clk) begin
    if (!rst_n) begin
      smp_q        <= '0;
      prev_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      post_eff_q   <= '0;
      armed_seen_q <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      forced_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      smp_q        <= ad_data;
      prev_q       <= smp_q;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      pre_len_q    <= pre_len_d;
      post_eff_q   <= post_eff_d;
      armed_seen_q <= armed_seen_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      forced_q     <= forced_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= smp_q;
    end
  end

  // Output decode of the state plus the registered write port.
  always_comb begin
    busy  = (state_q != S_IDLE);
    armed = (state_q == S_ARMED);
    done  = (state_q == S_DONE);
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign forced     = forced_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl with a 16-entry buffer. A behavioural
// model tracks the capture by phase and remaining window counts and
// predicts every output after each clock edge; directed scenarios pin
// the model with hand-computed addresses and counts, then random traffic
// runs against it.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  localparam int P_IDLE  = 0;
  localparam int P_PRE   = 1;
  localparam int P_ARMED = 2;
  localparam int P_POST  = 3;
  localparam int P_DONE  = 4;

  logic              ad_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] ad_data = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ack = 1'b0;
  logic              force_trig = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_slope = 1'b0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic [ADDR_W:0]   post_len = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              armed;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              forced;

  int compared = 0;
  int mismatched = 0;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .ad_clk(ad_clk), .rst_n(rst_n), .ad_data(ad_data), .start(start),
    .abort(abort), .ack(ack), .force_trig(force_trig),
    .trig_level(trig_level), .trig_slope(trig_slope),
    .pre_len(pre_len), .post_len(post_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .armed(armed), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr), .forced(forced)
  );

  always #5 ad_clk = ~ad_clk;

  // Model state: phase plus countdowns of samples still owed to each window.
  int mPhase, mWptr, mPreLen, mPostEff, mPreLeft, mPostLeft, mArmedWrites;
  int mSmp, mPrev;
  int eWrEn, eWrAddr, eWrData, eTrig, eStart, eForced;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelWrite();
    eWrEn   = 1;
    eWrAddr = mWptr;
    mWptr   = (mWptr + 1) % DEPTH;
  endtask

  // One clock edge of the reference behaviour, from the bench-held inputs.
  task automatic modelStep();
    int fire;
    int lvl;
    if (!rst_n) begin
      mPhase = P_IDLE; mWptr = 0; mPreLen = 0; mPostEff = 0;
      mPreLeft = 0; mPostLeft = 0; mArmedWrites = 0;
      mSmp = 0; mPrev = 0;
      eWrEn = 0; eWrAddr = 0; eWrData = 0; eTrig = 0; eStart = 0; eForced = 0;
    end else begin
      eWrEn   = 0;
      eWrData = mSmp;
      lvl     = int'(trig_level);
      if (abort) begin
        mPhase = P_IDLE;
      end else begin
        case (mPhase)
          P_IDLE: if (start) begin
            mPreLen  = int'(pre_len);
            mPostEff = int'(post_len);
            if (mPostEff > DEPTH - mPreLen) mPostEff = DEPTH - mPreLen;
            if (mPostEff < 1) mPostEff = 1;
            mWptr = 0; mArmedWrites = 0; mPreLeft = mPreLen;
            mPhase = (mPreLen > 0) ? P_PRE : P_ARMED;
          end
          P_PRE: begin
            modelWrite();
            mPreLeft--;
            if (mPreLeft == 0) mPhase = P_ARMED;
          end
          P_ARMED: begin
            if (trig_slope)
              fire = int'(mArmedWrites > 0 && mPrev > lvl && mSmp <= lvl);
            else
              fire = int'(mArmedWrites > 0 && mPrev < lvl && mSmp >= lvl);
            if (force_trig) fire = 1;
            if (fire != 0) begin
              eTrig   = mWptr;
              eStart  = (mWptr - mPreLen + DEPTH) % DEPTH;
              eForced = int'(force_trig);
              mPostLeft = mPostEff - 1;
              mPhase = (mPostLeft == 0) ? P_DONE : P_POST;
            end
            modelWrite();
            mArmedWrites++;
          end
          P_POST: begin
            modelWrite();
            mPostLeft--;
            if (mPostLeft == 0) mPhase = P_DONE;
          end
          P_DONE: if (ack) mPhase = P_IDLE;
          default: mPhase = P_IDLE;
        endcase
      end
      mPrev = mSmp;
      mSmp  = int'(ad_data);
    end
  endtask

  // Compare process: predict at the edge, check the DUT a little later.
  always @(posedge ad_clk) begin
    modelStep();
    #2;
    checkOutput("wr_en", 32'(wr_en), 32'(eWrEn));
    if (eWrEn != 0) checkOutput("wr_addr", 32'(wr_addr), 32'(eWrAddr));
    checkOutput("wr_data", 32'(wr_data), 32'(eWrData));
    checkOutput("busy", 32'(busy), 32'(mPhase != P_IDLE));
    checkOutput("armed", 32'(armed), 32'(mPhase == P_ARMED));
    checkOutput("done", 32'(done), 32'(mPhase == P_DONE));
    checkOutput("trig_addr", 32'(trig_addr), 32'(eTrig));
    checkOutput("start_addr", 32'(start_addr), 32'(eStart));
    checkOutput("forced", 32'(forced), 32'(eForced));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ad_clk);
      #4;
    end
  endtask

  // Drive one cycle of pulses, then drop them again.
  task automatic applyStimulus(input logic s, input logic a, input logic k, input logic f);
    start = s; abort = a; ack = k; force_trig = f;
    tick(1);
    start = 1'b0; abort = 1'b0; ack = 1'b0; force_trig = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick(1);
    checkOutput(name, 32'(done), 32'd1);
  endtask

  initial begin
    int wc;

    $display("[TB] reset");
    rst_n = 1'b0;
    tick(2);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
    rst_n = 1'b1;

    $display("[TB] rising ramp, pre=4 post=6 level=20");
    trig_level = 8'd20; trig_slope = 1'b0; pre_len = 4'd4; post_len = 5'd6;
    wc = 0;
    for (int n = 0; n < 60; n++) begin
      ad_data = 8'(n);
      start = (n == 0);
      tick(1);
      start = 1'b0;
      if (wr_en === 1'b1) wc++;
      if (done === 1'b1) break;
    end
    checkOutput("ramp_done", 32'(done), 32'd1);
    checkOutput("ramp_writes", 32'(wc), 32'd26);
    checkOutput("ramp_trig_addr", 32'(trig_addr), 32'd4);
    checkOutput("ramp_start_addr", 32'(start_addr), 32'd0);
    checkOutput("ramp_forced", 32'(forced), 32'd0);
    tick(1);
    checkOutput("ramp_idle_wr_en", 32'(wr_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ramp_ack_busy", 32'(busy), 32'd0);

    $display("[TB] falling steps, level=150");
    trig_level = 8'd150; trig_slope = 1'b1; pre_len = 4'd2; post_len = 5'd3;
    ad_data = 8'd150;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(20);
    checkOutput("flat_still_armed", 32'(armed), 32'd1);
    ad_data = 8'd200;
    tick(3);
    ad_data = 8'd100;
    waitDone("fall_done", 20);
    checkOutput("fall_forced", 32'(forced), 32'd0);
    checkOutput("fall_last_data", 32'(wr_data), 32'd100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] pre=0 post=1 forced");
    trig_level = 8'd200; trig_slope = 1'b0; pre_len = 4'd0; post_len = 5'd1;
    ad_data = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nopre_armed", 32'(armed), 32'd1);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("force_done", 32'(done), 32'd1);
    checkOutput("force_wr_en", 32'(wr_en), 32'd1);
    checkOutput("force_forced", 32'(forced), 32'd1);
    checkOutput("force_trig_addr", 32'(trig_addr), 32'd2);
    checkOutput("force_start_addr", 32'(start_addr), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] pre=10 post=20 clipped, wrap");
    pre_len = 4'd10; post_len = 5'd20; ad_data = 8'd50;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(13);
    wc = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    if (wr_en === 1'b1) wc++;
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      tick(1);
      if (wr_en === 1'b1) wc++;
    end
    checkOutput("clip_post_writes", 32'(wc), 32'd6);
    checkOutput("clip_trig_addr", 32'(trig_addr), 32'd13);
    checkOutput("clip_start_addr", 32'(start_addr), 32'd3);
    checkOutput("clip_last_addr", 32'(wr_addr), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] abort mid-POST");
    pre_len = 4'd1; post_len = 5'd10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_trig_addr", 32'(trig_addr), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_start_busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-ARMED, then ack");
    pre_len = 4'd3; post_len = 5'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_armed", 32'(armed), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 32'd0);
    pre_len = 4'd0; post_len = 5'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitDone("rst_then_done", 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ack_busy", 32'(busy), 32'd0);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      ad_data    = 8'($urandom_range(0, 255));
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      ack        = ($urandom_range(0, 3) == 0);
      force_trig = ($urandom_range(0, 24) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 15) == 0) begin
        trig_level = 8'($urandom_range(0, 255));
        trig_slope = 1'($urandom_range(0, 1));
        pre_len    = 4'($urandom_range(0, 15));
        post_len   = 5'($urandom_range(0, 31));
      end
      tick(1);
    end
    start = 1'b0; abort = 1'b0; ack = 1'b0; force_trig = 1'b0; rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
